// File: rtl/divider_arbiter_if.sv
// -----------------------------------------------------------------------------
// divider_arbiter_if
//   Start/idle handshake and operand/result bus between the divider arbiter and
//   a shared divider_8bit instance.
//   Signals:
//     strt       start pulse, one cycle, from arbiter
//     dividend   operand held by arbiter while the divider works
//     divisor    operand held by arbiter while the divider works
//     quotient   result from divider, valid when idle = 1
//     remainder  result from divider, valid when idle = 1
//     not_valid  divide-by-zero flag from divider
//     idle       1 = divider ready / result stable
//   Modports:
//     master  arbiter side (drives strt and operands)
//     slave   divider side (drives results and idle)
// -----------------------------------------------------------------------------
interface divider_arbiter_if;
  logic       strt;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       not_valid;
  logic       idle;

  modport master (
    output strt, dividend, divisor,
    input  quotient, remainder, not_valid, idle
  );

  modport slave (
    input  strt, dividend, divisor,
    output quotient, remainder, not_valid, idle
  );
endinterface

// File: rtl/divider_arbiter.sv
// -----------------------------------------------------------------------------
// divider_arbiter
//   Shares one divider_8bit between N_REQ requesters. Pending requests are
//   arbitrated round-robin, the winner's operands are latched and handed to the
//   divider with a one-cycle start pulse, and the result comes back to the
//   granted requester with a one-cycle done pulse. A divider that never reports
//   a busy/idle transition within BUSY_TIMEOUT cycles aborts the operation with
//   not_valid = 1 and sets the sticky timeout_err flag.
//   Ports:
//     clk           system clock, rising edge
//     rst           asynchronous active-low reset
//     req           per-requester request level
//     req_dividend  operands, slice i = [8*i+7:8*i]
//     req_divisor   operands, slice i = [8*i+7:8*i]
//     grant         one-hot owner of the divider
//     done          one-hot, one-cycle result-ready pulse
//     quotient      registered result, held until next completion
//     remainder     registered result, held until next completion
//     not_valid     registered divide-by-zero / timeout flag
//     timeout_err   sticky abort flag, cleared by reset only
//     div           master side of the divider handshake
// -----------------------------------------------------------------------------
module divider_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_dividend,
  input  logic [8*N_REQ-1:0]   req_divisor,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic [7:0]           quotient,
  output logic [7:0]           remainder,
  output logic                 not_valid,
  output logic                 timeout_err,
  divider_arbiter_if.master    div
);

  localparam int PW = $clog2(N_REQ);
  localparam int SW = PW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CAPTURE
  } state_t;

  state_t         state, state_n;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  cur_idx;
  logic [PW-1:0]  win_idx;
  logic           win_found;
  logic [TW-1:0]  tcnt;
  logic           idle_seen;
  logic           timed_out;
  logic           do_grant, do_capture, do_abort, strt_c;
  logic [7:0]     dvd [N_REQ];
  logic [7:0]     dvs [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign dvd[g] = req_dividend[8*g +: 8];
    assign dvs[g] = req_divisor[8*g +: 8];
  end

  // Round-robin pick: scan from the pointer upward with wrap; iterating from the
  // far end down lets the closest requester at or after the pointer win.
  always_comb begin : arb
    logic [SW-1:0] sum;
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    sum       = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      if (req[sum[PW-1:0]]) begin
        win_idx   = sum[PW-1:0];
        win_found = 1'b1;
      end
    end
  end

  assign timed_out = (tcnt >= TW'(BUSY_TIMEOUT - 1));

  always_comb begin : fsm_next
    state_n    = state;
    do_grant   = 1'b0;
    do_capture = 1'b0;
    do_abort   = 1'b0;
    strt_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found && div.idle) begin
          do_grant = 1'b1;
          state_n  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        strt_c  = 1'b1;
        state_n = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // Idle for two consecutive cycles means the divider finished before
        // its busy phase could be observed.
        if (!div.idle)      state_n = S_WAIT_DONE;
        else if (idle_seen) state_n = S_CAPTURE;
        else if (timed_out) begin
          do_abort = 1'b1;
          state_n  = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (div.idle) state_n = S_CAPTURE;
        else if (timed_out) begin
          do_abort = 1'b1;
          state_n  = S_IDLE;
        end
      end
      S_CAPTURE: begin
        do_capture = 1'b1;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign div.strt = strt_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant        <= '0;
      done         <= '0;
      quotient     <= '0;
      remainder    <= '0;
      not_valid    <= 1'b0;
      timeout_err  <= 1'b0;
      div.dividend <= '0;
      div.divisor  <= '0;
      ptr          <= '0;
      cur_idx      <= '0;
      tcnt         <= '0;
      idle_seen    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here sees
      // the pre-edge value of every other, regardless of statement order.
      done <= '0;

      if ((state == S_WAIT_BUSY || state == S_WAIT_DONE) &&
          (state_n == S_WAIT_BUSY || state_n == S_WAIT_DONE))
        tcnt <= tcnt + TW'(1);
      else
        tcnt <= '0;

      idle_seen <= (state == S_WAIT_BUSY) && div.idle;

      if (do_grant) begin
        grant        <= N_REQ'(1) << win_idx;
        cur_idx      <= win_idx;
        div.dividend <= dvd[win_idx];
        div.divisor  <= dvs[win_idx];
      end

      if (do_capture || do_abort) begin
        quotient  <= do_capture ? div.quotient  : 8'd0;
        remainder <= do_capture ? div.remainder : 8'd0;
        not_valid <= do_capture ? div.not_valid : 1'b1;
        done      <= grant;
        grant     <= '0;
        // An aborted requester also loses its turn, so a dead divider cannot
        // let one requester starve the others.
        ptr       <= (cur_idx == PW'(N_REQ - 1)) ? '0 : cur_idx + PW'(1);
      end

      if (do_abort) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// -----------------------------------------------------------------------------
// tb_divider_arbiter
//   Directed and randomized checks of divider_arbiter against a behavioural
//   divider model and a round-robin reference kept in the bench.
// -----------------------------------------------------------------------------
module tb_divider_arbiter;

  localparam int N = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [8*N-1:0]  req_dividend, req_divisor;
  logic [N-1:0]    grant, done;
  logic [7:0]      quotient, remainder;
  logic            not_valid, timeout_err;

  logic [7:0]      a_op [N];
  logic [7:0]      b_op [N];

  int total = 0;
  int bad   = 0;
  int rr_ptr = 0;
  int strt_cnt = 0;
  int lat = 3;
  bit fast = 1'b0;
  bit stuck = 1'b0;

  divider_arbiter_if bus ();

  divider_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .grant        (grant),
    .done         (done),
    .quotient     (quotient),
    .remainder    (remainder),
    .not_valid    (not_valid),
    .timeout_err  (timeout_err),
    .div          (bus)
  );

  assign req_dividend = {a_op[3], a_op[2], a_op[1], a_op[0]};
  assign req_divisor  = {b_op[3], b_op[2], b_op[1], b_op[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [7:0] b);
    return (b == 8'd0) ? 8'hFF : a / b;
  endfunction

  function automatic logic [7:0] ref_r(input logic [7:0] a, input logic [7:0] b);
    return (b == 8'd0) ? a : a % b;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // Behavioural divider: goes busy for 'lat' cycles after a start, or answers
  // instantly without ever dropping idle when 'fast' is set; 'stuck' freezes it busy.
  initial begin : divider_model
    int mcnt;
    logic [7:0] ma, mb;
    mcnt = 0; ma = '0; mb = '0;
    bus.idle = 1'b1; bus.quotient = '0; bus.remainder = '0; bus.not_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.strt === 1'b1) begin
        ma = bus.dividend; mb = bus.divisor;
        if (fast) begin
          bus.quotient = ref_q(ma, mb); bus.remainder = ref_r(ma, mb);
          bus.not_valid = (mb == 8'd0);
        end else begin
          bus.idle = 1'b0; mcnt = lat;
        end
      end else if (!bus.idle && !stuck) begin
        if (mcnt <= 1) begin
          bus.quotient = ref_q(ma, mb); bus.remainder = ref_r(ma, mb);
          bus.not_valid = (mb == 8'd0); bus.idle = 1'b1;
        end else mcnt--;
      end
    end
  end

  always @(negedge clk) if (bus.strt === 1'b1) strt_cnt <= strt_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1; rr_ptr = 0;
    @(negedge clk);
  endtask

  // One arbitrated transaction from request to done pulse.
  task automatic serve(input string tag, input logic [N-1:0] reqv, input bit keep,
                       input bit mutate, input bit expect_to,
                       output int n_grant, output int n_done);
    int w, s0;
    logic [7:0] ea, eb, eq, er;
    logic env;
    s0 = strt_cnt;
    req = reqv;
    w = rr_pick(reqv, rr_ptr);
    n_grant = 0;
    do begin @(negedge clk); n_grant++; end while (grant == '0 && n_grant < 40);
    check({tag, ".grant"}, 32'(grant), 32'(N'(1) << w));
    ea = a_op[w]; eb = b_op[w];
    if (mutate) begin
      a_op[w] = ea ^ 8'h5A; b_op[w] = eb + 8'd1; req = '0;
    end
    n_done = 0;
    do begin @(negedge clk); n_done++; end while (done == '0 && n_done < 200);
    if (expect_to) begin eq = 8'd0; er = 8'd0; env = 1'b1; end
    else begin eq = ref_q(ea, eb); er = ref_r(ea, eb); env = (eb == 8'd0); end
    check({tag, ".done"}, 32'(done), 32'(N'(1) << w));
    check({tag, ".q"}, 32'(quotient), 32'(eq));
    check({tag, ".r"}, 32'(remainder), 32'(er));
    check({tag, ".nv"}, 32'(not_valid), 32'(env));
    check({tag, ".grant_clr"}, 32'(grant), 32'd0);
    check({tag, ".strt_pulses"}, 32'(strt_cnt - s0), 32'd1);
    rr_ptr = (w + 1) % N;
    if (!keep) begin
      req = '0;
      @(negedge clk);
      check({tag, ".done_width"}, 32'(done), 32'd0);
    end
  endtask

  initial begin : stimulus
    int ng, nd;
    logic [N-1:0] seen;
    logic [N-1:0] rv;
    rst = 1'b0; req = '1;
    for (int i = 0; i < N; i++) begin a_op[i] = '0; b_op[i] = 8'd1; end
    repeat (3) @(negedge clk);
    check("reset.grant", 32'(grant), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.q", 32'(quotient), 32'd0);
    check("reset.r", 32'(remainder), 32'd0);
    check("reset.nv", 32'(not_valid), 32'd0);
    check("reset.terr", 32'(timeout_err), 32'd0);
    check("reset.strt", 32'(bus.strt), 32'd0);
    check("reset.dvd", 32'(bus.dividend), 32'd0);
    req = '0;
    @(negedge clk); rst = 1'b1; rr_ptr = 0;
    @(negedge clk);

    // Single request 100/7
    a_op[0] = 8'd100; b_op[0] = 8'd7; lat = 4;
    serve("single", 4'b0001, 1'b0, 1'b0, 1'b0, ng, nd);
    check("single.grant_lat", 32'(ng), 32'd1);
    check("single.q14", 32'(quotient), 32'd14);
    check("single.r2", 32'(remainder), 32'd2);

    // All four held: back-to-back round-robin from pointer 0
    apply_reset();
    for (int i = 0; i < N; i++) begin
      a_op[i] = 8'($urandom_range(0, 255)); b_op[i] = 8'($urandom_range(1, 255));
    end
    for (int t = 0; t < 5; t++) begin
      serve($sformatf("rr%0d", t), 4'b1111, (t < 4), 1'b0, 1'b0, ng, nd);
      if (t > 0) check($sformatf("rr%0d.b2b", t), 32'(ng), 32'd1);
    end

    // Divide by zero
    a_op[0] = 8'd100; b_op[0] = 8'd0; lat = 3;
    serve("div0", 4'b0001, 1'b0, 1'b0, 1'b0, ng, nd);
    check("div0.nv1", 32'(not_valid), 32'd1);
    check("div0.terr", 32'(timeout_err), 32'd0);

    // Divider stuck busy
    a_op[1] = 8'd9; b_op[1] = 8'd2; stuck = 1'b1;
    serve("tmo", 4'b0010, 1'b0, 1'b0, 1'b1, ng, nd);
    check("tmo.window", 32'(nd >= 32 && nd <= 34), 32'd1);
    check("tmo.terr", 32'(timeout_err), 32'd1);
    stuck = 1'b0;

    // Operands changed and req dropped after grant
    a_op[0] = 8'd200; b_op[0] = 8'd9; lat = 5;
    serve("latch", 4'b0001, 1'b0, 1'b1, 1'b0, ng, nd);
    check("latch.terr_sticky", 32'(timeout_err), 32'd1);

    // Reset while the divider is busy
    a_op[0] = 8'd77; b_op[0] = 8'd5; lat = 12; req = 4'b0001;
    ng = 0;
    do begin @(negedge clk); ng++; end while (grant == '0 && ng < 40);
    check("rst.grant", 32'(grant), 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.grant0", 32'(grant), 32'd0);
    check("rst.q0", 32'(quotient), 32'd0);
    check("rst.nv0", 32'(not_valid), 32'd0);
    check("rst.terr0", 32'(timeout_err), 32'd0);
    check("rst.dvd0", 32'(bus.dividend), 32'd0);
    seen = '0;
    repeat (3) begin @(negedge clk); seen |= done; end
    req = '0; rst = 1'b1; rr_ptr = 0;
    repeat (3) begin @(negedge clk); seen |= done; end
    check("rst.no_done", 32'(seen), 32'd0);
    a_op[0] = 8'd50; b_op[0] = 8'd6; lat = 2;
    serve("rst.after", 4'b0001, 1'b0, 1'b0, 1'b0, ng, nd);

    // Randomized traffic
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < N; i++) begin
        a_op[i] = 8'($urandom_range(0, 255));
        b_op[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
      lat  = $urandom_range(1, 6);
      fast = ($urandom_range(0, 4) == 0);
      rv   = 4'($urandom_range(1, 15));
      serve($sformatf("rnd%0d", t), rv, 1'b0, ($urandom_range(0, 3) == 0), 1'b0, ng, nd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
